// File: rtl/num_display_conv_if.sv
// Request/result bundle for num_display_conv: binary value in, display digits out.
// The requester uses the master modport; the converter uses the slave modport.
interface num_display_conv_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 2
);
   logic [WIDTH-1:0]    value;
   logic                hexMode;
   logic                in_valid;
   logic                in_ready;
   logic [4*DIGITS-1:0] digits;
   logic [DIGITS-1:0]   blank;
   logic                overflow;
   logic                out_valid;

   modport master (
      output value, hexMode, in_valid,
      input  in_ready, digits, blank, overflow, out_valid
   );

   modport slave (
      input  value, hexMode, in_valid,
      output in_ready, digits, blank, overflow, out_valid
   );
endinterface

// File: rtl/num_display_conv.sv
// Converts an unsigned binary value into hex or decimal display digits with leading-zero
// blanking and saturation on overflow; decimal uses a serial double-dabble, one bit per clock.
module num_display_conv #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   num_display_conv_if.slave  bus
);

   localparam int BCD_DIGITS = (WIDTH + 2) / 3 + 1;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int DEC_EXT    = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
   localparam int HEX_DIG    = (WIDTH + 3) / 4;
   localparam int HEX_EXT    = (HEX_DIG > DIGITS) ? HEX_DIG : DIGITS;
   localparam int VAL_EXT_W  = 4 * HEX_EXT;
   localparam int BCD_EXT_W  = 4 * DEC_EXT;
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [WIDTH-1:0]    r_shift;
   logic [BCD_W-1:0]    r_bcd;
   logic [CNT_W-1:0]    r_count;
   logic [4*DIGITS-1:0] r_digits;
   logic [DIGITS-1:0]   r_blank;
   logic                r_overflow;

   logic                w_accept;
   logic                w_lastStep;
   logic                w_useHex;
   logic [BCD_W-1:0]    w_bcdAdj;
   logic [BCD_W-1:0]    w_bcdShifted;
   logic [VAL_EXT_W-1:0] w_valExt;
   logic [BCD_EXT_W-1:0] w_bcdExt;
   logic                w_hexOvf;
   logic                w_decOvf;
   logic                w_resOvf;
   logic [4*DIGITS-1:0] w_resDigits;
   logic [DIGITS-1:0]   w_resBlank;

   assign w_accept   = bus.in_valid && (r_state == IDLE);
   assign w_lastStep = (r_count == CNT_W'(WIDTH));
   assign w_useHex   = (r_state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = bus.hexMode ? DONE : SHIFT;
         SHIFT:   if (w_lastStep) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == IDLE);
      bus.out_valid = (r_state == DONE);
      bus.digits    = r_digits;
      bus.blank     = r_blank;
      bus.overflow  = r_overflow;
   end

   // Double-dabble step: correct every BCD digit >= 5 by +3, then shift in the next MSB.
   always_comb begin
      w_bcdAdj = r_bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
      w_bcdShifted = {w_bcdAdj[BCD_W-2:0], r_shift[WIDTH-1]};
   end

   always_comb begin
      w_valExt = VAL_EXT_W'(bus.value);
      w_bcdExt = BCD_EXT_W'(r_bcd);
      w_hexOvf = 1'b0;
      for (int i = 4 * DIGITS; i < VAL_EXT_W; i++) begin
         w_hexOvf = w_hexOvf | w_valExt[i];
      end
      w_decOvf = 1'b0;
      for (int i = 4 * DIGITS; i < BCD_EXT_W; i++) begin
         w_decOvf = w_decOvf | w_bcdExt[i];
      end
   end

   // Hex results come straight from the request in IDLE; decimal results from the finished BCD.
   always_comb begin : resultComb
      logic zeroRun;
      w_resOvf = w_useHex ? w_hexOvf : w_decOvf;
      if (w_resOvf) begin
         w_resDigits = w_useHex ? {DIGITS{4'hF}} : {DIGITS{4'h9}};
      end else begin
         w_resDigits = w_useHex ? w_valExt[4*DIGITS-1:0] : w_bcdExt[4*DIGITS-1:0];
      end
      w_resBlank = '0;
      zeroRun    = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zeroRun       = zeroRun && (w_resDigits[4*i +: 4] == 4'h0);
         w_resBlank[i] = zeroRun && !w_resOvf;
      end
   end

   // After WIDTH shift steps the SHIFT state spends one more cycle latching the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= '0;
         r_bcd      <= '0;
         r_count    <= '0;
         r_digits   <= '0;
         r_blank    <= BLANK_RST;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (bus.hexMode) begin
                     r_digits   <= w_resDigits;
                     r_blank    <= w_resBlank;
                     r_overflow <= w_resOvf;
                  end else begin
                     r_shift <= bus.value;
                     r_bcd   <= '0;
                     r_count <= '0;
                  end
               end
            end
            SHIFT: begin
               if (!w_lastStep) begin
                  r_bcd   <= w_bcdShifted;
                  r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                  r_count <= r_count + CNT_W'(1);
               end else begin
                  r_digits   <= w_resDigits;
                  r_blank    <= w_resBlank;
                  r_overflow <= w_resOvf;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_num_display_conv.sv
// Randomised plus directed bench for num_display_conv; results are checked against a
// decimal/hex arithmetic model for a default (8-bit, 2-digit) and a 12-bit, 4-digit instance.
module tb_num_display_conv;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nBad;

   num_display_conv_if #(.WIDTH(8),  .DIGITS(2)) busA ();
   num_display_conv_if #(.WIDTH(12), .DIGITS(4)) busB ();

   num_display_conv #(.WIDTH(8), .DIGITS(2)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA.slave)
   );

   num_display_conv #(.WIDTH(12), .DIGITS(4)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain division for decimal, nibble extraction for hex, blanks above the top non-zero digit.
   task automatic model(input int unsigned val, input bit hex, input int digs,
                        output logic [31:0] expDigits, output logic [31:0] expBlank,
                        output logic [31:0] expOvf);
      int unsigned limit;
      int unsigned v;
      int          top;
      expDigits = '0;
      expBlank  = '0;
      limit     = 1;
      for (int i = 0; i < digs; i++) limit = limit * (hex ? 16 : 10);
      expOvf = (val >= limit) ? 32'd1 : 32'd0;
      v = val;
      for (int i = 0; i < digs; i++) begin
         if (expOvf != 0) expDigits[4*i +: 4] = hex ? 4'hF : 4'h9;
         else if (hex)    expDigits[4*i +: 4] = 4'((val >> (4 * i)) & 15);
         else begin
            expDigits[4*i +: 4] = 4'(v % 10);
            v = v / 10;
         end
      end
      if (expOvf == 0) begin
         top = 0;
         for (int i = 0; i < digs; i++) if (expDigits[4*i +: 4] != 4'h0) top = i;
         for (int i = top + 1; i < digs; i++) expBlank[i] = 1'b1;
      end
   endtask

   task automatic driveReq(input int sel, input int unsigned val, input bit hex, input bit vld);
      if (sel == 0) begin
         busA.value    = 8'(val);
         busA.hexMode  = hex;
         busA.in_valid = vld;
      end else begin
         busB.value    = 12'(val);
         busB.hexMode  = hex;
         busB.in_valid = vld;
      end
   endtask

   function automatic logic outValid(input int sel);
      return (sel == 0) ? busA.out_valid : busB.out_valid;
   endfunction

   function automatic logic inReady(input int sel);
      return (sel == 0) ? busA.in_ready : busB.in_ready;
   endfunction

   // One request on instance sel; optionally pokes in_valid while busy to show it is ignored.
   task automatic applyStimulus(input int sel, input int unsigned val, input bit hex, input bit pulseBusy);
      logic [31:0] expDigits, expBlank, expOvf, obsDigits, obsBlank, obsOvf;
      int          width, digs, lat, guard;
      width = (sel == 0) ? 8 : 12;
      digs  = (sel == 0) ? 2 : 4;
      model(val, hex, digs, expDigits, expBlank, expOvf);
      guard = 0;
      while (!inReady(sel) && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      driveReq(sel, val, hex, 1'b1);
      @(posedge clk); #1;
      driveReq(sel, val, hex, 1'b0);
      lat = 0;
      while (!outValid(sel) && lat < 40) begin
         driveReq(sel, $urandom, hex ^ 1'b1, pulseBusy && lat[0]);
         @(posedge clk); #1;
         lat++;
      end
      driveReq(sel, val, hex, 1'b0);
      obsDigits = (sel == 0) ? 32'(busA.digits)   : 32'(busB.digits);
      obsBlank  = (sel == 0) ? 32'(busA.blank)    : 32'(busB.blank);
      obsOvf    = (sel == 0) ? 32'(busA.overflow) : 32'(busB.overflow);
      checkOutput("latency",  32'(lat), hex ? 32'd0 : 32'(width + 1));
      checkOutput("digits",   obsDigits, expDigits);
      checkOutput("blank",    obsBlank,  expBlank);
      checkOutput("overflow", obsOvf,    expOvf);
      if (pulseBusy) driveReq(sel, val, hex, 1'b1);
      @(posedge clk); #1;
      driveReq(sel, val, hex, 1'b0);
      checkOutput("readyAfterDone", 32'(inReady(sel)), 32'd1);
      checkOutput("pulseEnds", 32'(outValid(sel)), 32'd0);
      obsDigits = (sel == 0) ? 32'(busA.digits) : 32'(busB.digits);
      checkOutput("digitsHeld", obsDigits, expDigits);
   endtask

   initial begin
      int okCycles;
      nChecks = 0;
      nBad    = 0;
      rst_n   = 1'b0;
      driveReq(0, 0, 1'b0, 1'b0);
      driveReq(1, 0, 1'b0, 1'b0);
      #12;
      checkOutput("rstDigits",   32'(busA.digits),    32'h0);
      checkOutput("rstBlank",    32'(busA.blank),     32'b10);
      checkOutput("rstOverflow", 32'(busA.overflow),  32'd0);
      checkOutput("rstValid",    32'(busA.out_valid), 32'd0);
      checkOutput("rstBlankB",   32'(busB.blank),     32'b1110);
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("rstReady", 32'(busA.in_ready), 32'd1);
      @(posedge clk); #1;

      applyStimulus(0, 57,    1'b0, 1'b0);
      applyStimulus(0, 200,   1'b0, 1'b0);
      applyStimulus(0, 8'hA3, 1'b1, 1'b1);
      applyStimulus(0, 57,    1'b0, 1'b1);
      applyStimulus(0, 7,     1'b0, 1'b0);
      applyStimulus(0, 0,     1'b0, 1'b0);
      applyStimulus(0, 99,    1'b0, 1'b0);
      applyStimulus(0, 100,   1'b0, 1'b0);
      applyStimulus(0, 8'h0C, 1'b1, 1'b0);
      applyStimulus(1, 4095,  1'b0, 1'b0);
      applyStimulus(1, 12'h0AB, 1'b1, 1'b0);
      applyStimulus(1, 0,     1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         applyStimulus(0, $urandom_range(0, 255), 1'($urandom), 1'($urandom));
      end
      for (int n = 0; n < 10; n++) begin
         applyStimulus(1, $urandom_range(0, 4095), 1'($urandom), 1'($urandom));
      end

      // Back-to-back: in_valid held high re-accepts in the first IDLE cycle after DONE.
      driveReq(0, 8'h5E, 1'b1, 1'b1);
      @(posedge clk); #1;
      checkOutput("b2bFirst", 32'(busA.out_valid), 32'd1);
      @(posedge clk); #1;
      checkOutput("b2bIdle", 32'(busA.in_ready), 32'd1);
      driveReq(0, 8'h42, 1'b1, 1'b1);
      @(posedge clk); #1;
      driveReq(0, 0, 1'b0, 1'b0);
      checkOutput("b2bSecond", 32'(busA.out_valid), 32'd1);
      checkOutput("b2bDigits", 32'(busA.digits), 32'h42);
      @(posedge clk); #1;

      // Reset in the middle of a decimal conversion of 99.
      driveReq(0, 99, 1'b0, 1'b1);
      @(posedge clk); #1;
      driveReq(0, 0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstDigits",   32'(busA.digits),    32'h0);
      checkOutput("midRstBlank",    32'(busA.blank),     32'b10);
      checkOutput("midRstOverflow", 32'(busA.overflow),  32'd0);
      checkOutput("midRstValid",    32'(busA.out_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("midRstReady", 32'(busA.in_ready), 32'd1);
      okCycles = 0;
      for (int c = 0; c < 15; c++) begin
         if (!busA.out_valid) okCycles++;
         @(posedge clk); #1;
      end
      checkOutput("noStaleValid", 32'(okCycles), 32'd15);
      applyStimulus(0, 42, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
